// File: rtl/ctr_pipe_adder_if.sv
// Operand/result bus for ctr_pipe_adder: one valid/ready channel in, one out.
// Handshake: a beat transfers on a rising clock edge where valid && ready; the
// source holds valid and payload stable until that edge, and ready may depend
// combinationally on the sink's downstream ready.
interface ctr_pipe_adder_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             carry_out;

  modport master (
    output in_valid, sub, a, b, out_ready,
    input  in_ready, out_valid, s, carry_out
  );

  modport slave (
    input  in_valid, sub, a, b, out_ready,
    output in_ready, out_valid, s, carry_out
  );
endinterface

// File: rtl/ctr_pipe_adder.sv
// Deskewed pipelined WIDTH-bit adder/subtractor, one SEG-bit segment per stage,
// with a single global advance enable and synchronous flush.
module ctr_pipe_adder #(
  parameter int WIDTH = 128,
  parameter int SEG   = 32
) (
  input logic              i_clk,
  input logic              i_rst,
  input logic              i_flush,
  ctr_pipe_adder_if.slave  bus
);
  // WIDTH must be a multiple of SEG.
  localparam int N = WIDTH / SEG;

  logic w_adv;
  logic w_out_valid;

  assign w_adv        = !w_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv && !i_flush;

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int REM  = WIDTH - k * SEG;
    localparam int DONE = (k + 1) * SEG;

    logic [REM-1:0]  w_a;
    logic [REM-1:0]  w_b;
    logic            w_ci;
    logic            w_vi;
    logic [SEG:0]    w_sum;
    logic [DONE-1:0] w_s_next;

    logic [DONE-1:0] r_s;
    logic            r_c;
    logic            r_v;

    // Stage k sees only its unprocessed operand bits, LSB-aligned to segment k.
    if (k == 0) begin : g_first
      assign w_a      = bus.a;
      assign w_b      = bus.sub ? ~bus.b : bus.b;
      assign w_ci     = bus.sub;
      assign w_vi     = bus.in_valid;
      assign w_s_next = w_sum[SEG-1:0];
    end else begin : g_next
      assign w_a      = g_stage[k-1].g_fwd.r_a;
      assign w_b      = g_stage[k-1].g_fwd.r_b;
      assign w_ci     = g_stage[k-1].r_c;
      assign w_vi     = g_stage[k-1].r_v;
      assign w_s_next = {w_sum[SEG-1:0], g_stage[k-1].r_s};
    end

    assign w_sum = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_ci};

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_s <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else begin
        if (i_flush) begin
          r_v <= 1'b0;
        end else if (w_adv) begin
          r_v <= w_vi;
        end
        if (w_adv) begin
          r_s <= w_s_next;
          r_c <= w_sum[SEG];
        end
      end
    end

    if (k < N - 1) begin : g_fwd
      logic [REM-SEG-1:0] r_a;
      logic [REM-SEG-1:0] r_b;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[REM-1:SEG];
          r_b <= w_b[REM-1:SEG];
        end
      end
    end
  end

  assign w_out_valid   = g_stage[N-1].r_v;
  assign bus.out_valid = w_out_valid;
  assign bus.s         = g_stage[N-1].r_s;
  assign bus.carry_out = g_stage[N-1].r_c;
endmodule

// File: doc/ctr_pipe_adder.md
Name: ctr_pipe_adder

Overview:
- Parametrised, fully aligned pipelined adder/subtractor for CTR-mode counter generation in the IBR128 datapath.
- Splits a WIDTH-bit operation into SEG-bit carry-rippled stages; each stage pipeline-skews operands so every segment sees its own operands with the correct carry.
- Adds valid/ready flow control, subtract mode, carry/borrow-out and synchronous flush.

Parameters:
- WIDTH, 128, operand/result width in bits; must be a multiple of SEG.
- SEG, 32, segment width per pipeline stage; N = WIDTH/SEG stages, N >= 1.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- Flush  in  1  synchronous clear of all in-flight operations.
- In_Valid  in  1  operand set presented.
- In_Ready  out  1  block can accept this cycle.
- Sub  in  1  0: S = A + B; 1: S = A - B; sampled with operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Out_Valid  out  1  result available.
- Out_Ready  in  1  downstream accepts result.
- S  out  WIDTH  result, modulo 2^WIDTH.
- Carry_Out  out  1  add: carry out of MSB; sub: 1 = no borrow (A >= B unsigned).

Behaviour:
- Reset (Rst high, async): all stage valid bits 0, all data and carry registers 0; Out_Valid=0, S=0, Carry_Out=0. In_Ready=1 from the first edge after Rst deasserts.
- Transfer rules: input accepted when In_Valid && In_Ready; output consumed when Out_Valid && Out_Ready.
- Global advance enable: adv = !Out_Valid || Out_Ready.
  - In_Ready = adv. This is combinational from Out_Ready; no internal skid buffer.
  - When adv=0, every stage register holds its value. S, Carry_Out and Out_Valid stay stable while Out_Valid && !Out_Ready.
- Subtract: on accept, B is replaced by ~B and the stage-0 carry-in is set to Sub (two's complement). The sum is then computed exactly as an add.
- Stage k (0..N-1), on adv:
  - adds segment k of the stored A and B plus the carry from stage k-1.
  - forwards the upper unprocessed operand segments, the completed lower sum segments, the new carry and the valid bit to stage k+1.
  - Operands are captured once at accept; no later change on A/B/Sub affects an accepted item.
- Latency: exactly N cycles from accept to Out_Valid, with Out_Ready held high. N=1 gives a single registered adder.
- Throughput: one result per cycle with Out_Ready high.
  - Bubbles (In_Valid low) propagate as invalid slots.
  - Results emerge in accept order.
  - All WIDTH bits of S belong to the same operand set (deskewed, unlike a free-running staggered adder).
- Carry_Out is the carry from the final stage and is registered alongside S.
- Wrap-around: sums exceeding 2^WIDTH-1 wrap modulo 2^WIDTH with Carry_Out=1. Subtraction below zero wraps with Carry_Out=0.
- Flush: at the next edge, all stage valid bits and Out_Valid clear; data registers are don't-care.
  - Flush has priority over adv and over any accept in that cycle; In_Valid is not accepted when Flush=1 (In_Ready driven 0 while Flush=1).
- Rst asserted mid-operation: immediate clear of all in-flight items; no partial result is ever presented.
- Simultaneous output consume and input accept in the same cycle is legal and loses nothing.

Test Plan:
- Reset/idle (WIDTH=128, SEG=32): assert Rst mid-stream with 3 items in flight -> Out_Valid=0, S=0, Carry_Out=0 immediately; no stale result after release.
- Full carry ripple: A=2^128-1, B=1, Sub=0, Out_Ready=1 -> after exactly 4 cycles S=0, Carry_Out=1; A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1 -> S=0x...1_0000_0000_0000_0000, Carry_Out=0.
- Subtract/borrow: A=5, B=7, Sub=1 -> S=2^128-2, Carry_Out=0; A=7, B=5, Sub=1 -> S=2, Carry_Out=1.
- Back-to-back CTR stream: B=1, A=0..9 on consecutive cycles with operands changing every cycle -> S=1..10 on consecutive cycles, in order, each fully deskewed.
- Backpressure: stream 6 items, drop Out_Ready for 3 cycles after the first result -> In_Ready=0 while stalled, S/Carry_Out unchanged, all 6 results delivered once, in order, no duplicates.
- Flush: 3 items in flight, pulse Flush with In_Valid=1 -> that input not accepted, Out_Valid=0 next cycle, a new item accepted after the flush emerges N=4 cycles later with the correct sum; repeat with SEG=WIDTH (N=1) for latency 1.
